// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin arbiter for the regfile write port,
// with a per-register busy scoreboard and read-after-write hazard detection.
module regfile_wb_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            v0,
    input  logic [2:0]      a0,
    input  logic [DW-1:0]   d0,
    output logic            r0,
    input  logic            v1,
    input  logic [2:0]      a1w,
    input  logic [DW-1:0]   d1,
    output logic            r1,
    input  logic            iss_v,
    input  logic [2:0]      iss_a,
    input  logic [2:0]      ra1,
    input  logic [2:0]      ra2,
    input  logic            ru1,
    input  logic            ru2,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    output logic            we3,
    output logic [2:0]      a3,
    output logic [DW-1:0]   wd3
);
    logic            last;
    logic            acc;
    logic [2:0]      wa;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;

    // On contention the requester that did not win last time goes next
    assign r0     = !reset && !stall && v0 && (!v1 || last);
    assign r1     = !reset && !stall && v1 && (!v0 || !last);
    assign acc    = r0 || r1;
    assign wa     = r0 ? a0 : a1w;
    assign clr    = acc ? NREG'(1) << wa : '0;
    assign set    = iss_v ? NREG'(1) << iss_a : '0;
    assign hazard = !reset && ((ru1 && busy[ra1]) || (ru2 && busy[ra2]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3  <= 1'b0;
            a3   <= '0;
            wd3  <= '0;
            busy <= '0;
            last <= 1'b1;
        end else begin
            we3 <= acc;
            if (acc) begin
                a3   <= wa;
                wd3  <= r0 ? d0 : d1;
                last <= r1;
            end
            // A new issue to the same register outranks the retiring write
            busy <= (busy & ~clr) | set;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed stimulus, per-cycle compare against a
// behavioural scoreboard/arbiter model, plus hand-computed literal checks.
module tb_regfile_wb_ctrl;
    logic        clk = 0;
    logic        reset = 1;
    logic        stall = 0;
    logic        v0 = 0, v1 = 0, iss_v = 0, ru1 = 0, ru2 = 0;
    logic [2:0]  a0 = 0, a1w = 0, iss_a = 0, ra1 = 0, ra2 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    logic        r0, r1, hazard, we3;
    logic [7:0]  busy;
    logic [2:0]  a3;
    logic [15:0] wd3;

    int checks = 0;
    int failures = 0;

    bit          m_busy [8];
    int          m_last = 1;
    bit          m_we = 0;
    int          m_a = 0;
    int          m_wd = 0;
    bit          e0, e1, eh;
    logic [7:0]  eb;

    regfile_wb_ctrl #(.NREG(8), .DW(16)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .v0(v0), .a0(a0), .d0(d0), .r0(r0),
        .v1(v1), .a1w(a1w), .d1(d1), .r1(r1),
        .iss_v(iss_v), .iss_a(iss_a), .ra1(ra1), .ra2(ra2), .ru1(ru1), .ru2(ru2),
        .hazard(hazard), .busy(busy), .we3(we3), .a3(a3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: compare at the falling edge, then advance to the state after the next rising edge
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
            m_last = 1;
            m_we = 0;
            m_a = 0;
            m_wd = 0;
        end
        e0 = 0;
        e1 = 0;
        if (!reset && !stall) begin
            if (v0 && v1) begin
                if (m_last == 0) e1 = 1; else e0 = 1;
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        for (int i = 0; i < 8; i++) eb[i] = m_busy[i];
        eh = !reset && ((ru1 && m_busy[ra1]) || (ru2 && m_busy[ra2]));
        chk("m_r0", 32'(r0), 32'(e0));
        chk("m_r1", 32'(r1), 32'(e1));
        chk("m_hazard", 32'(hazard), 32'(eh));
        chk("m_busy", 32'(busy), 32'(eb));
        chk("m_we3", 32'(we3), 32'(m_we));
        chk("m_a3", 32'(a3), m_a);
        chk("m_wd3", 32'(wd3), m_wd);
        if (!reset) begin
            m_we = e0 || e1;
            if (e0) begin m_a = a0; m_wd = d0; m_busy[a0] = 0; m_last = 0; end
            if (e1) begin m_a = a1w; m_wd = d1; m_busy[a1w] = 0; m_last = 1; end
            if (iss_v) m_busy[iss_a] = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        step();
        step();
        reset = 0;
        chk("rst_we3", 32'(we3), 0);
        chk("rst_a3", 32'(a3), 0);
        chk("rst_wd3", 32'(wd3), 0);
        chk("rst_busy", 32'(busy), 0);

        // single write, one-cycle latency
        v0 = 1; a0 = 1; d0 = 16'habcd;
        #2 chk("t1_r0", 32'(r0), 1);
        step();
        v0 = 0;
        chk("t1_we3", 32'(we3), 1);
        chk("t1_a3", 32'(a3), 1);
        chk("t1_wd3", 32'(wd3), 32'h abcd);
        step();
        chk("t1_we3_off", 32'(we3), 0);

        // continuous contention alternates 0,1,0,1
        do_reset();
        v0 = 1; a0 = 2; d0 = 16'h0123;
        v1 = 1; a1w = 3; d1 = 16'hcccc;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t2_r0", 32'(r0), (i % 2 == 0) ? 1 : 0);
            chk("t2_r1", 32'(r1), (i % 2 == 0) ? 0 : 1);
            if (i > 0) chk("t2_wd3", 32'(wd3), (i % 2 == 1) ? 32'h0123 : 32'hcccc);
            step();
        end
        v0 = 0; v1 = 0;
        chk("t2_wd3_last", 32'(wd3), 32'hcccc);
        chk("t2_a3_last", 32'(a3), 3);

        // scoreboard set, hazard, clear by writeback
        iss_v = 1; iss_a = 3;
        step();
        iss_v = 0; ra1 = 3; ru1 = 1;
        #2 chk("t3_hazard", 32'(hazard), 1);
        chk("t3_busy", 32'(busy), 32'b00001000);
        v1 = 1; a1w = 3; d1 = 16'h5555;
        #1 chk("t3_r1", 32'(r1), 1);
        step();
        v1 = 0;
        #1 chk("t3_busy_clr", 32'(busy), 0);
        chk("t3_hazard_clr", 32'(hazard), 0);
        ru1 = 0;

        // same-cycle set and clear
        iss_v = 1; iss_a = 1; v0 = 1; a0 = 1; d0 = 16'h1111;
        step();
        iss_v = 0; v0 = 0;
        chk("t4_same", 32'(busy), 32'b00000010);
        iss_v = 1; iss_a = 2; v0 = 1; a0 = 1;
        step();
        iss_v = 0; v0 = 0;
        chk("t4_diff", 32'(busy), 32'b00000100);

        // stall blocks grants; requester 0 first after reset
        do_reset();
        stall = 1; v0 = 1; v1 = 1; a0 = 4; d0 = 16'h4444; a1w = 7; d1 = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t5_r0", 32'(r0), 0);
            chk("t5_r1", 32'(r1), 0);
            chk("t5_we3", 32'(we3), 0);
            step();
        end
        stall = 0;
        #2 chk("t5_r0_rel", 32'(r0), 1);
        chk("t5_r1_rel", 32'(r1), 0);
        step();
        v0 = 0; v1 = 0;

        // async reset drops a registered write and clears busy
        iss_v = 1; iss_a = 6;
        step();
        iss_v = 0; v0 = 1; a0 = 5; d0 = 16'hbeef;
        step();
        v0 = 0;
        chk("t6_we3", 32'(we3), 1);
        chk("t6_busy", 32'(busy), 32'b01000000);
        reset = 1;
        #1 chk("t6_we3_rst", 32'(we3), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        step();
        reset = 0;
        step();
        chk("t6_we3_after", 32'(we3), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
